copro_cmd_deframer: RTL and testbench
=====================================

// Module: copro_cmd_deframer
// PURPOSE
// - Sits downstream of soc_system's fifo_to_copro_out port (HPS->coprocessor FIFO, Avalon-MM read side).
// - Pulls 32-bit words, parses packet headers, emits payload as a valid/ready stream to the accelerator.
// - Reports progress and error counts on a status word that loops back to pio_status_export.
// PARAMETERS
// - DATA_W   32    payload/FIFO word width (header layout fixed for 32)
// - MAX_LEN  4096  largest legal payload length in words; must be <= 65535
// PORTS
// - clk               in   1       single clock, same domain as soc_system clk_clk
// - reset             in   1       synchronous, active-high
// - fifo_read         out  1       Avalon-MM read request to fifo_to_copro_out_read
// - fifo_readdata     in   DATA_W  from fifo_to_copro_out_readdata
// - fifo_waitrequest  in   1       from fifo_to_copro_out_waitrequest
// - m_valid           out  1       payload word available
// - m_ready           in   1       accelerator accepts the word
// - m_data            out  DATA_W  payload word
// - m_sop / m_eop     out  1 each  first / last word of packet (both 1 when N==1)
// - m_opcode          out  8       opcode of the packet owning m_data
// - err_clear         in   1       single-cycle pulse: zero the error counter
// - status            out  32      [31:24] last opcode, [23:16] err_cnt, [15:0] pkt_cnt
// BEHAVIOUR
// - Transfer rule: a FIFO word is accepted in a cycle with fifo_read=1 and fifo_waitrequest=0.
//   readdata is valid in that same cycle (zero read latency).
// - Header word: [31:24] opcode, [23:16] magic 8'hA5, [15:0] N = payload word count.
// - FSM HDR:
//   - fifo_read=1 only while the buffer is empty.
//   - Accepted word with magic==A5 and 1<=N<=MAX_LEN: latch opcode and N, load down-counter rem=N, go to PAY.
//   - Any other accepted word is dropped, err_cnt+1 (saturates at 255), FSM stays in HDR. Magic check is the resync mechanism.
// - FSM PAY:
//   - fifo_read = (buf_count<2); registered state only, no combinational path from m_ready.
//   - Each accepted word is pushed into the buffer tagged {opcode, sop=(rem==N), eop=(rem==1)}; rem decrements.
//   - Accepting the eop word returns the FSM to HDR in the next cycle.
// - Output buffer: 2-entry skid (42 bits/entry).
//   - m_valid = buf_count!=0; outputs driven from head entry.
//   - Push and pop in the same cycle are both honoured.
//   - Throughput 1 word/clk in steady state.
// - Counters:
//   - pkt_cnt+1 (16-bit, wraps) on an m_valid&m_ready&m_eop pop.
//   - status[31:24] updates when a valid header is latched.
//   - err_clear concurrent with an error: clear wins, err_cnt=0.
// - Reset values: fifo_read=0, m_valid=0, m_sop=0, m_eop=0, m_data=0, m_opcode=0, status=0.
//   Reset also sets FSM=HDR and empties the buffer.
// - Reset mid-packet drops all buffered words.
//   Remaining payload in the FIFO is parsed as headers and rejected (err_cnt counts) until a valid header is found.
// - m_valid held with stable data until m_ready (no retraction).
// STRUCTURE
// - copro_pkg:
//   - HDR_MAGIC=8'hA5 and field positions (OPC_MSB/LSB, MAGIC_MSB/LSB, LEN_MSB/LSB)
//   - state enum {HDR, PAY}
//   - status field offsets, shared with the HPS driver headers
// - One sub-module, copro_skid_buf: 2-entry FIFO with push/pop/count; width parameterised.
// TESTING
// - Header 0x01A50003 + words 11,22,33, m_ready=1:
//   - 3 beats, sop on 11, eop on 33, m_opcode=0x01
//   - pkt_cnt=1, status=0x01000001
// - Same packet, m_ready=0 for 10 cycles:
//   - buffer fills to 2, fifo_read drops to 0, no word lost or duplicated after release
// - Words 0xDEAD0001, 0x02A50000, 0x03A51001 (N=4097>MAX_LEN), then valid 0x04A50001+0x55:
//   - err_cnt=3, single beat 0x55 sop=eop=1, opcode 0x04
// - fifo_waitrequest toggled pseudo-randomly during a 64-word packet:
//   - data order preserved; fifo_read never depends on m_ready combinationally
// - reset asserted after 2 of 5 payload words, then FIFO delivers 3 leftovers + a valid packet:
//   - outputs zero after reset, err_cnt=3, next packet delivered intact
// - 256 bad headers, then err_clear coincident with a 257th bad header:
//   - err_cnt saturates at 255, then reads 0

Source files
------------

// File: rtl/copro_pkg.sv
// Shared definitions for the coprocessor command deframer.
// Purpose : header field positions, header magic, deframer states and
//           status word field offsets (the HPS driver headers use the same
//           offsets to decode pio_status_export).
// Ports   : none (package).
package copro_pkg;

   // Header word layout: [31:24] opcode, [23:16] magic, [15:0] payload length
   localparam int OPC_MSB   = 31;
   localparam int OPC_LSB   = 24;
   localparam int MAGIC_MSB = 23;
   localparam int MAGIC_LSB = 16;
   localparam int LEN_MSB   = 15;
   localparam int LEN_LSB   = 0;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;

   // Status word layout: [31:24] last opcode, [23:16] err_cnt, [15:0] pkt_cnt
   localparam int ST_OPC_LSB = 24;
   localparam int ST_ERR_LSB = 16;
   localparam int ST_PKT_LSB = 0;

   typedef enum logic {
      HDR = 1'b0,
      PAY = 1'b1
   } deframer_state_t;

endpackage

// File: rtl/copro_skid_buf.sv
// Two-entry FIFO used as the output skid buffer of the deframer.
// Purpose : decouples the FIFO read side from accelerator back-pressure while
//           sustaining one word per clock; push and pop may happen together.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           push, push_data - write an entry (ignored only when full without pop)
//           pop             - remove the head entry (ignored when empty)
//           head            - current head entry
//           count           - number of stored entries (0..2)
module copro_skid_buf #(
   parameter int W = 42
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   // A full buffer can still take a push when the head leaves in the same cycle.
   assign do_push = push && ((count != 2'd2) || pop);
   assign do_pop  = pop && (count != 2'd0);
   assign head    = mem[rd_ptr];

   // Storage is cleared on reset so the head (and thus m_data) reads zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/copro_cmd_deframer.sv
// Coprocessor command deframer.
// Purpose : reads 32-bit words from the HPS->coprocessor FIFO (Avalon-MM read
//           side, zero read latency), validates packet headers, and streams
//           the payload to the accelerator with sop/eop/opcode tags.
// Ports   : clk, reset        - clock, synchronous active-high reset
//           fifo_read         - Avalon-MM read request
//           fifo_readdata     - FIFO word, valid in the accepting cycle
//           fifo_waitrequest  - FIFO stall
//           m_valid/m_ready   - payload stream handshake
//           m_data            - payload word
//           m_sop/m_eop       - first/last payload word of a packet
//           m_opcode          - opcode of the packet owning m_data
//           err_clear         - pulse that zeroes the error counter
//           status            - {last opcode, err_cnt, pkt_cnt}
import copro_pkg::*;

module copro_cmd_deframer #(
   parameter int DATA_W  = 32,
   parameter int MAX_LEN = 4096
) (
   input  logic              clk,
   input  logic              reset,
   output logic              fifo_read,
   input  logic [DATA_W-1:0] fifo_readdata,
   input  logic              fifo_waitrequest,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_sop,
   output logic              m_eop,
   output logic [7:0]        m_opcode,
   input  logic              err_clear,
   output logic [31:0]       status
);

   localparam int          ENT_W     = DATA_W + 10;
   localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

   deframer_state_t state, state_nxt;

   logic [7:0]       opcode_q;
   logic [15:0]      len_q;
   logic [15:0]      rem_q;
   logic [7:0]       last_opc;
   logic [7:0]       err_cnt;
   logic [15:0]      pkt_cnt;

   logic [7:0]       hdr_opc;
   logic [7:0]       hdr_magic;
   logic [15:0]      hdr_len;
   logic             hdr_ok;
   logic             hdr_take;
   logic             hdr_err;
   logic             push;
   logic             pop;
   logic [ENT_W-1:0] push_ent;
   logic [ENT_W-1:0] head_ent;
   logic [1:0]       buf_count;

   assign hdr_opc   = fifo_readdata[OPC_MSB:OPC_LSB];
   assign hdr_magic = fifo_readdata[MAGIC_MSB:MAGIC_LSB];
   assign hdr_len   = fifo_readdata[LEN_MSB:LEN_LSB];
   assign hdr_ok    = (hdr_magic == HDR_MAGIC) && (hdr_len != 16'd0) && (hdr_len <= MAX_LEN_W);

   // Entry layout: {opcode, sop, eop, data}; rem counts down from N to 1.
   assign push_ent = {opcode_q, (rem_q == len_q), (rem_q == 16'd1), fifo_readdata};

   copro_skid_buf #(.W(ENT_W)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_ent),
      .pop       (pop),
      .head      (head_ent),
      .count     (buf_count)
   );

   assign m_valid  = (buf_count != 2'd0);
   assign m_data   = head_ent[DATA_W-1:0];
   assign m_eop    = head_ent[DATA_W];
   assign m_sop    = head_ent[DATA_W+1];
   assign m_opcode = head_ent[DATA_W+9:DATA_W+2];
   assign pop      = m_valid && m_ready;

   assign status = {last_opc, err_cnt, pkt_cnt};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= HDR;
      end else begin
         state <= state_nxt;
      end
   end

   // Read request comes only from state and buffer occupancy, never from
   // m_ready, so the FIFO interface has no combinational path from the sink.
   // Reads are suppressed during reset so no FIFO word is consumed and lost.
   // Headers are read only with an empty buffer so a new packet's tags never
   // overtake words of the previous packet still waiting at the output.
   always_comb begin
      state_nxt = state;
      fifo_read = 1'b0;
      hdr_take  = 1'b0;
      hdr_err   = 1'b0;
      push      = 1'b0;
      case (state)
         HDR: begin
            fifo_read = !reset && (buf_count == 2'd0);
            if (fifo_read && !fifo_waitrequest) begin
               if (hdr_ok) begin
                  hdr_take  = 1'b1;
                  state_nxt = PAY;
               end else begin
                  hdr_err = 1'b1;
               end
            end
         end
         PAY: begin
            fifo_read = !reset && (buf_count < 2'd2);
            if (fifo_read && !fifo_waitrequest) begin
               push = 1'b1;
               if (rem_q == 16'd1) begin
                  state_nxt = HDR;
               end
            end
         end
         default: state_nxt = HDR;
      endcase
   end

   // Packet context, progress and error counters. A clear request beats a
   // concurrent error; the error count sticks at 255.
   always_ff @(posedge clk) begin
      if (reset) begin
         opcode_q <= 8'd0;
         len_q    <= 16'd0;
         rem_q    <= 16'd0;
         last_opc <= 8'd0;
         err_cnt  <= 8'd0;
         pkt_cnt  <= 16'd0;
      end else begin
         if (hdr_take) begin
            opcode_q <= hdr_opc;
            len_q    <= hdr_len;
            rem_q    <= hdr_len;
            last_opc <= hdr_opc;
         end else if (push) begin
            rem_q <= rem_q - 16'd1;
         end
         if (err_clear) begin
            err_cnt <= 8'd0;
         end else if (hdr_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
         end
         if (pop && m_eop) begin
            pkt_cnt <= pkt_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_copro_cmd_deframer.sv
// Self-checking bench for copro_cmd_deframer: a FIFO model feeds words, a
// packet-level reference model predicts the beats and status, and the
// received beats are compared in order.
module tb_copro_cmd_deframer;

   logic        clk = 1'b0;
   logic        reset;
   logic        fifo_read;
   logic [31:0] fifo_readdata;
   logic        fifo_waitrequest;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_sop;
   logic        m_eop;
   logic [7:0]  m_opcode;
   logic        err_clear;
   logic [31:0] status;

   int checks   = 0;
   int failures = 0;

   // FIFO contents and beat queues; a beat is {opcode, sop, eop, data}
   logic [31:0] fifo_q [$];
   logic [41:0] exp_q  [$];
   logic [41:0] rcv_q  [$];

   // Reference model state (packet level)
   bit          mdl_in_pay;
   int          mdl_len;
   int          mdl_idx;
   logic [7:0]  mdl_opc;
   logic [7:0]  mdl_last_opc;
   int          mdl_err;
   int          mdl_pkt;

   // Stimulus knobs and protocol watchers
   int          stall_pct;
   int          ready_pct;
   bit          clr_pending;
   bit          hold_prev;
   logic [41:0] prev_beat;
   int          comb_viol;
   int          retract_viol;

   copro_cmd_deframer #(.DATA_W(32), .MAX_LEN(4096)) dut (
      .clk              (clk),
      .reset            (reset),
      .fifo_read        (fifo_read),
      .fifo_readdata    (fifo_readdata),
      .fifo_waitrequest (fifo_waitrequest),
      .m_valid          (m_valid),
      .m_ready          (m_ready),
      .m_data           (m_data),
      .m_sop            (m_sop),
      .m_eop            (m_eop),
      .m_opcode         (m_opcode),
      .err_clear        (err_clear),
      .status           (status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reference model: parse the word stream by the packet rules.
   task automatic model_reset();
      mdl_in_pay   = 0;
      mdl_len      = 0;
      mdl_idx      = 0;
      mdl_opc      = 8'h00;
      mdl_last_opc = 8'h00;
      mdl_err      = 0;
      mdl_pkt      = 0;
   endtask

   task automatic send_word(input logic [31:0] w);
      int n;
      fifo_q.push_back(w);
      if (!mdl_in_pay) begin
         n = int'(w[15:0]);
         if (w[23:16] == 8'hA5 && n >= 1 && n <= 4096) begin
            mdl_in_pay   = 1;
            mdl_len      = n;
            mdl_idx      = 0;
            mdl_opc      = w[31:24];
            mdl_last_opc = w[31:24];
         end else if (mdl_err < 255) begin
            mdl_err++;
         end
      end else begin
         exp_q.push_back({mdl_opc, (mdl_idx == 0), (mdl_idx == mdl_len - 1), w});
         mdl_idx++;
         if (mdl_idx == mdl_len) begin
            mdl_in_pay = 0;
            mdl_pkt++;
         end
      end
   endtask

   function automatic logic [31:0] bad_word();
      logic [31:0] w;
      w = $urandom;
      if (w[23:16] == 8'hA5) w[23:16] = 8'h5A;
      return w;
   endfunction

   // One clock: drive inputs at the falling edge, sample before the rising edge.
   task automatic tick();
      logic        rd0;
      logic [41:0] beat;
      if (fifo_q.size() > 0) begin
         fifo_readdata    = fifo_q[0];
         fifo_waitrequest = ($urandom_range(0, 99) < stall_pct);
      end else begin
         fifo_readdata    = $urandom;
         fifo_waitrequest = 1'b1;
      end
      m_ready   = ($urandom_range(0, 99) < ready_pct);
      err_clear = clr_pending;
      #1;
      rd0     = fifo_read;
      m_ready = !m_ready;
      #1;
      if (fifo_read !== rd0) comb_viol++;
      m_ready = !m_ready;
      #1;
      beat = {m_opcode, m_sop, m_eop, m_data};
      if (hold_prev && (!m_valid || beat !== prev_beat)) retract_viol++;
      if (fifo_read && !fifo_waitrequest && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (m_valid && m_ready) rcv_q.push_back(beat);
      hold_prev = m_valid && !m_ready && !reset;
      prev_beat = beat;
      @(posedge clk);
      @(negedge clk);
      clr_pending = 0;
      err_clear   = 1'b0;
   endtask

   task automatic drain(input string tag);
      int budget = 3000;
      while ((fifo_q.size() != 0 || m_valid) && budget > 0) begin
         tick();
         budget--;
      end
      tick();
      tick();
      check({tag, "_timeout"}, 64'(budget == 0), 64'd0);
   endtask

   task automatic compare_beats(input string tag);
      int n;
      check({tag, "_beat_count"}, 64'(rcv_q.size()), 64'(exp_q.size()));
      n = (rcv_q.size() < exp_q.size()) ? rcv_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_beat%0d", tag, i), 64'(rcv_q[i]), 64'(exp_q[i]));
      end
      check({tag, "_status"}, 64'(status), 64'({mdl_last_opc, 8'(mdl_err), 16'(mdl_pkt)}));
      rcv_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fifo_read"}, 64'(fifo_read), 64'd0);
      check({tag, "_m_valid"},   64'(m_valid),   64'd0);
      check({tag, "_m_sop"},     64'(m_sop),     64'd0);
      check({tag, "_m_eop"},     64'(m_eop),     64'd0);
      check({tag, "_m_data"},    64'(m_data),    64'd0);
      check({tag, "_m_opcode"},  64'(m_opcode),  64'd0);
      check({tag, "_status"},    64'(status),    64'd0);
   endtask

   initial begin
      logic [31:0] w;
      logic [7:0]  opc;

      reset            = 1'b1;
      fifo_readdata    = 32'h0;
      fifo_waitrequest = 1'b1;
      m_ready          = 1'b0;
      err_clear        = 1'b0;
      stall_pct        = 0;
      ready_pct        = 100;
      clr_pending      = 0;
      hold_prev        = 0;
      comb_viol        = 0;
      retract_viol     = 0;
      model_reset();

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      reset = 1'b0;
      @(negedge clk);

      // Basic 3-word packet, sink always ready
      $display("[TB] basic packet");
      send_word(32'h01A50003);
      send_word(32'd11);
      send_word(32'd22);
      send_word(32'd33);
      drain("basic");
      check("basic_status_const", 64'(status), 64'h01000001);
      compare_beats("basic");

      // Same packet with the sink stalled for 10 cycles
      $display("[TB] back-pressure");
      ready_pct = 0;
      send_word(32'h01A50003);
      send_word(32'd11);
      send_word(32'd22);
      send_word(32'd33);
      repeat (10) tick();
      check("bp_valid_held", 64'(m_valid), 64'd1);
      check("bp_fifo_read_low", 64'(fifo_read), 64'd0);
      check("bp_words_left", 64'(fifo_q.size()), 64'd1);
      ready_pct = 100;
      drain("bp");
      compare_beats("bp");

      // Bad headers followed by a single-word packet
      $display("[TB] resync");
      send_word(32'hDEAD0001);
      send_word(32'h02A50000);
      send_word(32'h03A51001);
      send_word(32'h04A50001);
      send_word(32'h00000055);
      drain("resync");
      check("resync_err_cnt", 64'(status[23:16]), 64'd3);
      compare_beats("resync");

      // 64-word packet with random FIFO stalls and random sink readiness
      $display("[TB] random stalls");
      stall_pct = 50;
      ready_pct = 60;
      opc = 8'($urandom);
      send_word({opc, 8'hA5, 16'd64});
      for (int i = 0; i < 64; i++) send_word($urandom);
      drain("rand");
      compare_beats("rand");
      check("rand_no_comb_ready_path", 64'(comb_viol), 64'd0);
      check("rand_no_retraction", 64'(retract_viol), 64'd0);
      stall_pct = 0;
      ready_pct = 100;

      // Reset after 2 of 5 payload words
      $display("[TB] reset mid-packet");
      send_word({8'h07, 8'hA5, 16'd5});
      send_word($urandom);
      send_word($urandom);
      drain("mid_pre");
      compare_beats("mid_pre");
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("mid_rst");
      reset     = 1'b0;
      hold_prev = 0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) send_word(bad_word());
      send_word({8'h09, 8'hA5, 16'd2});
      send_word($urandom);
      send_word($urandom);
      ready_pct = 70;
      drain("mid_post");
      check("mid_err_cnt", 64'(status[23:16]), 64'd3);
      compare_beats("mid_post");
      ready_pct = 100;

      // Error counter saturation, then clear coincident with an error
      $display("[TB] error saturation");
      for (int i = 0; i < 256; i++) send_word(bad_word());
      drain("sat");
      check("sat_err_cnt", 64'(status[23:16]), 64'd255);
      compare_beats("sat");
      w = bad_word();
      fifo_q.push_back(w);
      clr_pending = 1;
      mdl_err     = 0;
      fifo_readdata    = w;
      fifo_waitrequest = 1'b0;
      #1;
      check("clr_read_accepted", 64'(fifo_read), 64'd1);
      tick();
      check("clr_err_cnt", 64'(status[23:16]), 64'd0);
      check("clr_fifo_consumed", 64'(fifo_q.size()), 64'd0);
      compare_beats("clr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: observed=timeout expected=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
